multicycle_control: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS control decoder.
- Decodes OP/Func once per instruction, registers the resulting control word, and sequences FETCH/DECODE/EXEC/MEM/WB through an FSM.
- Supports memory wait-states (MemReady handshake), a parametrised multiply latency, a configurable ALU_OP width, and a SYSCALL halt/resume state.
- Sits between the instruction register and the datapath of the next-generation CPU.

---
 rtl/multicycle_control_if.sv | 47 ++++
 rtl/multicycle_control.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Interface between the instruction register / datapath and the multi-cycle control FSM.
// The slave modport is the controller's view; the master modport is the datapath side.
interface multicycle_control_if #(
    parameter int ALU_OP_W = 4
);
    logic [5:0]          OP;
    logic [5:0]          Func;
    logic                MemReady;
    logic                Go;
    logic                PCWrite;
    logic                PCWriteCond;
    logic                IRWrite;
    logic                MemRead;
    logic                MemWrite;
    logic                RegWrite;
    logic                RegDst;
    logic                MemToReg;
    logic                ALU_SRC;
    logic                SignedExt;
    logic                LB;
    logic                SRAV;
    logic                Beq;
    logic                Bne;
    logic                BLTZ;
    logic                JMP;
    logic                JR;
    logic                JAL;
    logic [ALU_OP_W-1:0] ALU_OP;
    logic                SysCALL;
    logic                Halted;
    logic                IllegalOp;
    logic [2:0]          State;

    modport slave (
        input  OP, Func, MemReady, Go,
        output PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite,
               RegDst, MemToReg, ALU_SRC, SignedExt, LB, SRAV, Beq, Bne, BLTZ,
               JMP, JR, JAL, ALU_OP, SysCALL, Halted, IllegalOp, State
    );

    modport master (
        output OP, Func, MemReady, Go,
        input  PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite,
               RegDst, MemToReg, ALU_SRC, SignedExt, LB, SRAV, Beq, Bne, BLTZ,
               JMP, JR, JAL, ALU_OP, SysCALL, Halted, IllegalOp, State
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control: decodes OP/Func once in DECODE, registers the control word,
// and sequences FETCH/DECODE/EXEC/MEM/WB with memory wait-states, MULTU latency and HALT.
//
// state  | meaning
// FETCH  | read instruction, wait for MemReady, load IR and PC+4
// DECODE | decode OP/Func, register control word
// EXEC   | ALU / branch / jump, MULTU held for MUL_LAT cycles
// MEM    | load or store, wait for MemReady
// WB     | register file write
// HALT   | SYSCALL, wait for Go
module multicycle_control #(
    parameter int ALU_OP_W = 4,
    parameter int MUL_LAT  = 3
) (
    input  logic [4:0]                  LOGISIM_CLOCK_TREE_0,
    input  logic                        Reset_n,
    multicycle_control_if.slave         bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src;
        logic       signed_ext;
        logic       lb;
        logic       srav;
        logic       beq;
        logic       bne;
        logic       bltz;
        logic       jmp;
        logic       jr;
        logic       jal;
        logic       is_load;
        logic       is_store;
        logic       is_mul;
    } ctrl_t;

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    wire w_clk        = LOGISIM_CLOCK_TREE_0[4];
    wire w_unused_clk = ^LOGISIM_CLOCK_TREE_0[3:0];

    state_t           r_state;
    state_t           w_next;
    ctrl_t            r_ctrl;
    ctrl_t            w_dec;
    logic [CNT_W-1:0] r_mul_cnt;
    logic             w_legal, w_syscall;
    logic             w_pc_write, w_pc_cond, w_ir_write, w_mem_read, w_mem_write, w_reg_write;
    logic             w_illegal, w_halt, w_lvl_en;

    always_comb begin
        w_dec     = '0;
        w_legal   = 1'b1;
        w_syscall = 1'b0;
        if (bus.OP == 6'h00) begin
            w_dec.reg_dst = 1'b1;
            case (bus.Func)
                6'h00: w_dec.alu_op = 4'd0;
                6'h03: w_dec.alu_op = 4'd1;
                6'h02: w_dec.alu_op = 4'd2;
                6'h07: begin w_dec.alu_op = 4'd1; w_dec.srav = 1'b1; end
                6'h08: begin w_dec.reg_dst = 1'b0; w_dec.jr = 1'b1; end
                6'h0C: begin w_dec.reg_dst = 1'b0; w_syscall = 1'b1; end
                6'h19: begin w_dec.alu_op = 4'd3; w_dec.is_mul = 1'b1; end
                6'h20, 6'h21: w_dec.alu_op = 4'd5;
                6'h22: w_dec.alu_op = 4'd6;
                6'h24: w_dec.alu_op = 4'd7;
                6'h25: w_dec.alu_op = 4'd8;
                6'h26: w_dec.alu_op = 4'd9;
                6'h27: w_dec.alu_op = 4'd10;
                6'h2A: w_dec.alu_op = 4'd11;
                6'h2B: w_dec.alu_op = 4'd12;
                default: w_legal = 1'b0;
            endcase
        end else begin
            case (bus.OP)
                6'h01: begin w_dec.alu_op = 4'd6; w_dec.bltz = 1'b1; end
                6'h02: w_dec.jmp = 1'b1;
                6'h03: w_dec.jal = 1'b1;
                6'h04: begin w_dec.alu_op = 4'd6; w_dec.beq = 1'b1; end
                6'h05: begin w_dec.alu_op = 4'd6; w_dec.bne = 1'b1; end
                6'h08, 6'h09: begin w_dec.alu_op = 4'd5; w_dec.signed_ext = 1'b1; w_dec.alu_src = 1'b1; end
                6'h0A: begin w_dec.alu_op = 4'd11; w_dec.signed_ext = 1'b1; w_dec.alu_src = 1'b1; end
                6'h0C: begin w_dec.alu_op = 4'd7; w_dec.alu_src = 1'b1; end
                6'h0D: begin w_dec.alu_op = 4'd8; w_dec.alu_src = 1'b1; end
                6'h0E: begin w_dec.alu_op = 4'd9; w_dec.alu_src = 1'b1; end
                6'h20, 6'h23: begin
                    w_dec.alu_op     = 4'd5;
                    w_dec.signed_ext = 1'b1;
                    w_dec.alu_src    = 1'b1;
                    w_dec.mem_to_reg = 1'b1;
                    w_dec.is_load    = 1'b1;
                    w_dec.lb         = (bus.OP == 6'h20);
                end
                6'h2B: begin
                    w_dec.alu_op     = 4'd5;
                    w_dec.signed_ext = 1'b1;
                    w_dec.alu_src    = 1'b1;
                    w_dec.is_store   = 1'b1;
                end
                default: w_legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge w_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_FETCH;
            r_ctrl    <= '0;
            r_mul_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_ctrl    <= w_dec;
                r_mul_cnt <= CNT_W'(MUL_LAT - 1);
            end else if (r_state == S_EXEC && r_mul_cnt != '0) begin
                r_mul_cnt <= r_mul_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_pc_cond   = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        w_halt      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (bus.MemReady) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!w_legal) begin
                    w_illegal = 1'b1;
                    w_next    = S_FETCH;
                end else if (w_syscall) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_ctrl.beq || r_ctrl.bne || r_ctrl.bltz) begin
                    w_pc_cond = 1'b1;
                    w_next    = S_FETCH;
                end else if (r_ctrl.jmp || r_ctrl.jr || r_ctrl.jal) begin
                    w_pc_write  = 1'b1;
                    w_reg_write = r_ctrl.jal;
                    w_next      = S_FETCH;
                end else if (r_ctrl.is_mul) begin
                    if (r_mul_cnt == '0) w_next = S_WB;
                end else if (r_ctrl.is_load || r_ctrl.is_store) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                if (r_ctrl.is_store) begin
                    w_mem_write = 1'b1;
                    if (bus.MemReady) w_next = S_FETCH;
                end else begin
                    w_mem_read = 1'b1;
                    if (bus.MemReady) w_next = S_WB;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_HALT: begin
                w_halt = 1'b1;
                if (bus.Go) w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset_n gates every output so nothing is visible while reset is held.
    assign w_lvl_en = Reset_n && (r_state == S_EXEC || r_state == S_MEM ||
                                  r_state == S_WB   || r_state == S_HALT);

    assign bus.PCWrite     = Reset_n & w_pc_write;
    assign bus.PCWriteCond = Reset_n & w_pc_cond;
    assign bus.IRWrite     = Reset_n & w_ir_write;
    assign bus.MemRead     = Reset_n & w_mem_read;
    assign bus.MemWrite    = Reset_n & w_mem_write;
    assign bus.RegWrite    = Reset_n & w_reg_write;
    assign bus.IllegalOp   = Reset_n & w_illegal;
    assign bus.SysCALL     = Reset_n & w_halt;
    assign bus.Halted      = Reset_n & w_halt;
    assign bus.State       = Reset_n ? r_state : 3'd0;

    assign bus.RegDst    = w_lvl_en & r_ctrl.reg_dst;
    assign bus.MemToReg  = w_lvl_en & r_ctrl.mem_to_reg;
    assign bus.ALU_SRC   = w_lvl_en & r_ctrl.alu_src;
    assign bus.SignedExt = w_lvl_en & r_ctrl.signed_ext;
    assign bus.LB        = w_lvl_en & r_ctrl.lb;
    assign bus.SRAV      = w_lvl_en & r_ctrl.srav;
    assign bus.Beq       = w_lvl_en & r_ctrl.beq;
    assign bus.Bne       = w_lvl_en & r_ctrl.bne;
    assign bus.BLTZ      = w_lvl_en & r_ctrl.bltz;
    assign bus.JMP       = w_lvl_en & r_ctrl.jmp;
    assign bus.JR        = w_lvl_en & r_ctrl.jr;
    assign bus.JAL       = w_lvl_en & r_ctrl.jal;
    assign bus.ALU_OP    = w_lvl_en ? ALU_OP_W'(r_ctrl.alu_op) : '0;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected state/strobe/level vectors.
// dut_a uses defaults (MUL_LAT=3, ALU_OP_W=4); dut_b uses MUL_LAT=1, ALU_OP_W=6.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] clk_tree;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;
    assign clk_tree = {clk, 4'b0000};

    multicycle_control_if #(.ALU_OP_W(4)) bus_a ();
    multicycle_control_if #(.ALU_OP_W(6)) bus_b ();

    multicycle_control #(.ALU_OP_W(4), .MUL_LAT(3)) dut_a (
        .LOGISIM_CLOCK_TREE_0 (clk_tree),
        .Reset_n              (rst_n),
        .bus                  (bus_a)
    );

    multicycle_control #(.ALU_OP_W(6), .MUL_LAT(1)) dut_b (
        .LOGISIM_CLOCK_TREE_0 (clk_tree),
        .Reset_n              (rst_n),
        .bus                  (bus_b)
    );

    // {State, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite,
    //  RegDst, MemToReg, ALU_SRC, SignedExt, LB, SRAV, Beq, Bne, BLTZ, JMP, JR, JAL,
    //  ALU_OP, IllegalOp, SysCALL, Halted}
    wire [27:0] obs_a = {bus_a.State, bus_a.PCWrite, bus_a.PCWriteCond, bus_a.IRWrite,
                         bus_a.MemRead, bus_a.MemWrite, bus_a.RegWrite,
                         bus_a.RegDst, bus_a.MemToReg, bus_a.ALU_SRC, bus_a.SignedExt,
                         bus_a.LB, bus_a.SRAV, bus_a.Beq, bus_a.Bne, bus_a.BLTZ,
                         bus_a.JMP, bus_a.JR, bus_a.JAL, bus_a.ALU_OP,
                         bus_a.IllegalOp, bus_a.SysCALL, bus_a.Halted};
    wire [29:0] obs_b = {bus_b.State, bus_b.PCWrite, bus_b.PCWriteCond, bus_b.IRWrite,
                         bus_b.MemRead, bus_b.MemWrite, bus_b.RegWrite,
                         bus_b.RegDst, bus_b.MemToReg, bus_b.ALU_SRC, bus_b.SignedExt,
                         bus_b.LB, bus_b.SRAV, bus_b.Beq, bus_b.Bne, bus_b.BLTZ,
                         bus_b.JMP, bus_b.JR, bus_b.JAL, bus_b.ALU_OP,
                         bus_b.IllegalOp, bus_b.SysCALL, bus_b.Halted};

    localparam logic [27:0] FETCH_IDLE = {3'd0, 6'b000100, 12'h000, 4'd0, 3'b000};
    localparam logic [27:0] FETCH_RDY  = {3'd0, 6'b101100, 12'h000, 4'd0, 3'b000};
    localparam logic [27:0] DECODE_V   = {3'd1, 6'b000000, 12'h000, 4'd0, 3'b000};

    task automatic test_reset();
        rst_n = 1'b0;
        bus_a.MemReady = 1'b1; bus_a.Go = 1'b1;
        bus_b.MemReady = 1'b1; bus_b.Go = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        checks++;
        if (obs_a !== 28'h0) begin errors++; $display("FAIL reset_a got %h expected %h", obs_a, 28'h0); end
        checks++;
        if (obs_b !== 30'h0) begin errors++; $display("FAIL reset_b got %h expected %h", obs_b, 30'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.MemReady = 1'b0; bus_a.Go = 1'b0;
        bus_b.MemReady = 1'b0; bus_b.Go = 1'b0;
        #1;
        checks++;
        if (obs_a !== FETCH_IDLE) begin errors++; $display("FAIL reset_release got %h expected %h", obs_a, FETCH_IDLE); end
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [27:0] e [5];
        logic        mr [5];
        bus_a.OP = 6'h00; bus_a.Func = 6'h20;
        mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        e  = '{FETCH_RDY, DECODE_V,
               {3'd2, 6'b000000, 12'h800, 4'd5, 3'b000},
               {3'd4, 6'b000001, 12'h800, 4'd5, 3'b000},
               FETCH_IDLE};
        for (int i = 0; i < 5; i++) begin
            bus_a.MemReady = mr[i];
            #1;
            checks++;
            if (obs_a !== e[i]) begin errors++; $display("FAIL add cyc %0d got %h expected %h", i, obs_a, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_load_wait();
        logic [27:0] e [10];
        logic        mr [10];
        bus_a.OP = 6'h23; bus_a.Func = 6'h00;
        mr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        e  = '{FETCH_IDLE, FETCH_IDLE, FETCH_RDY, DECODE_V,
               {3'd2, 6'b000000, 12'h700, 4'd5, 3'b000},
               {3'd3, 6'b000100, 12'h700, 4'd5, 3'b000},
               {3'd3, 6'b000100, 12'h700, 4'd5, 3'b000},
               {3'd3, 6'b000100, 12'h700, 4'd5, 3'b000},
               {3'd4, 6'b000001, 12'h700, 4'd5, 3'b000},
               FETCH_IDLE};
        for (int i = 0; i < 10; i++) begin
            bus_a.MemReady = mr[i];
            #1;
            checks++;
            if (obs_a !== e[i]) begin errors++; $display("FAIL lw_wait cyc %0d got %h expected %h", i, obs_a, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_multu();
        logic [27:0] e [7];
        logic        mr [7];
        bus_a.OP = 6'h00; bus_a.Func = 6'h19;
        mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        e  = '{FETCH_RDY, DECODE_V,
               {3'd2, 6'b000000, 12'h800, 4'd3, 3'b000},
               {3'd2, 6'b000000, 12'h800, 4'd3, 3'b000},
               {3'd2, 6'b000000, 12'h800, 4'd3, 3'b000},
               {3'd4, 6'b000001, 12'h800, 4'd3, 3'b000},
               FETCH_IDLE};
        for (int i = 0; i < 7; i++) begin
            bus_a.MemReady = mr[i];
            #1;
            checks++;
            if (obs_a !== e[i]) begin errors++; $display("FAIL multu_lat3 cyc %0d got %h expected %h", i, obs_a, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_multu_lat1();
        logic [29:0] e [5];
        logic        mr [5];
        bus_b.OP = 6'h00; bus_b.Func = 6'h19;
        mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        e  = '{{3'd0, 6'b101100, 12'h000, 6'b000000, 3'b000},
               {3'd1, 6'b000000, 12'h000, 6'b000000, 3'b000},
               {3'd2, 6'b000000, 12'h800, 6'b000011, 3'b000},
               {3'd4, 6'b000001, 12'h800, 6'b000011, 3'b000},
               {3'd0, 6'b000100, 12'h000, 6'b000000, 3'b000}};
        for (int i = 0; i < 5; i++) begin
            bus_b.MemReady = mr[i];
            #1;
            checks++;
            if (obs_b !== e[i]) begin errors++; $display("FAIL multu_lat1 cyc %0d got %h expected %h", i, obs_b, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [27:0] e  [7];
        logic        mr [7];
        logic [5:0]  op [7];
        bus_a.Func = 6'h00;
        op = '{6'h04, 6'h04, 6'h04, 6'h03, 6'h03, 6'h03, 6'h03};
        mr = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        e  = '{FETCH_RDY, DECODE_V,
               {3'd2, 6'b010000, 12'h020, 4'd6, 3'b000},
               FETCH_RDY, DECODE_V,
               {3'd2, 6'b100001, 12'h001, 4'd0, 3'b000},
               FETCH_IDLE};
        for (int i = 0; i < 7; i++) begin
            bus_a.OP = op[i]; bus_a.MemReady = mr[i];
            #1;
            checks++;
            if (obs_a !== e[i]) begin errors++; $display("FAIL beq_jal cyc %0d got %h expected %h", i, obs_a, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_itype();
        logic [27:0] e  [9];
        logic        mr [9];
        logic [5:0]  op [9];
        logic [5:0]  fn [9];
        op = '{6'h0D, 6'h0D, 6'h0D, 6'h0D, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        fn = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h07, 6'h07, 6'h07, 6'h07, 6'h07};
        mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        e  = '{FETCH_RDY, DECODE_V,
               {3'd2, 6'b000000, 12'h200, 4'd8, 3'b000},
               {3'd4, 6'b000001, 12'h200, 4'd8, 3'b000},
               FETCH_RDY, DECODE_V,
               {3'd2, 6'b000000, 12'h840, 4'd1, 3'b000},
               {3'd4, 6'b000001, 12'h840, 4'd1, 3'b000},
               FETCH_IDLE};
        for (int i = 0; i < 9; i++) begin
            bus_a.OP = op[i]; bus_a.Func = fn[i]; bus_a.MemReady = mr[i];
            #1;
            checks++;
            if (obs_a !== e[i]) begin errors++; $display("FAIL ori_srav cyc %0d got %h expected %h", i, obs_a, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        logic [27:0] e  [9];
        logic        mr [9];
        logic        go [9];
        localparam logic [27:0] HALT_V = {3'd5, 6'b000000, 12'h000, 4'd0, 3'b011};
        bus_a.OP = 6'h00; bus_a.Func = 6'h0C;
        mr = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        go = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        e  = '{FETCH_RDY, DECODE_V, HALT_V, FETCH_RDY, DECODE_V,
               HALT_V, HALT_V, HALT_V, FETCH_IDLE};
        for (int i = 0; i < 9; i++) begin
            bus_a.MemReady = mr[i]; bus_a.Go = go[i];
            #1;
            checks++;
            if (obs_a !== e[i]) begin errors++; $display("FAIL syscall cyc %0d got %h expected %h", i, obs_a, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [27:0] e  [5];
        logic        mr [5];
        logic [5:0]  op [5];
        localparam logic [27:0] ILL_V = {3'd1, 6'b000000, 12'h000, 4'd0, 3'b100};
        bus_a.Func = 6'h3F;
        op = '{6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00};
        mr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        e  = '{FETCH_RDY, ILL_V, FETCH_RDY, ILL_V, FETCH_IDLE};
        for (int i = 0; i < 5; i++) begin
            bus_a.OP = op[i]; bus_a.MemReady = mr[i];
            #1;
            checks++;
            if (obs_a !== e[i]) begin errors++; $display("FAIL illegal cyc %0d got %h expected %h", i, obs_a, e[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [27:0] e  [5];
        logic        mr [5];
        localparam logic [27:0] MEMW_V = {3'd3, 6'b000010, 12'h300, 4'd5, 3'b000};
        bus_a.OP = 6'h2B; bus_a.Func = 6'h00;
        mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        e  = '{FETCH_RDY, DECODE_V,
               {3'd2, 6'b000000, 12'h300, 4'd5, 3'b000},
               MEMW_V, MEMW_V};
        for (int i = 0; i < 5; i++) begin
            bus_a.MemReady = mr[i];
            #1;
            checks++;
            if (obs_a !== e[i]) begin errors++; $display("FAIL sw_wait cyc %0d got %h expected %h", i, obs_a, e[i]); end
            @(negedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_a !== 28'h0) begin errors++; $display("FAIL sw_async_reset got %h expected %h", obs_a, 28'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs_a !== FETCH_IDLE) begin errors++; $display("FAIL sw_after_release got %h expected %h", obs_a, FETCH_IDLE); end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.OP = 6'h00; bus_a.Func = 6'h00; bus_a.MemReady = 1'b0; bus_a.Go = 1'b0;
        bus_b.OP = 6'h00; bus_b.Func = 6'h00; bus_b.MemReady = 1'b0; bus_b.Go = 1'b0;
        test_reset();
        test_add();
        test_load_wait();
        test_multu();
        test_multu_lat1();
        test_back_to_back();
        test_itype();
        test_halt();
        test_illegal();
        test_reset_mid_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
